pokey_poly_sched: RTL and testbench
===================================

Name: pokey_poly_sched

Overview:
- Sequencer for the POKEY 9/17-bit polynomial counter and its clock prescalers.
- Derives the 64 kHz and 15 kHz base ticks from the machine clock-enable, drives the poly counter's enable, init and 9/17 select inputs, and services CPU reads of the RANDOM register.
- Sits between the POKEY register file (SKCTL/AUDCTL/RANDOM decode) and the poly counter and audio channels.

Parameters:
DIV_64K, 28, machine-cycle divide ratio for the 64 kHz tick
DIV_15K, 114, machine-cycle divide ratio for the 15 kHz tick
INIT_RAND, 8'hFF, value returned on RANDOM reads while in INIT

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
ce  in  1  machine-cycle clock enable (~1.79 MHz); all state advances only when ce=1
skctl_init  in  1  1 = SKCTL[1:0]==00 (POKEY init mode)
audctl_poly9  in  1  AUDCTL[7]; 1 selects the 9-bit poly
rand_in  in  8  RANDOM value from the poly counter
rand_rd  in  1  single-clk pulse, CPU read of RANDOM
poly_enable  out  1  enable to poly counter
poly_init  out  1  init to poly counter
select_9_17  out  1  9/17 select to poly counter
tick_64k  out  1  one-ce-cycle pulse every DIV_64K ce cycles
tick_15k  out  1  one-ce-cycle pulse every DIV_15K ce cycles
rand_data  out  8  latched RANDOM read data
rand_valid  out  1  one-clk pulse, rand_data updated

Behaviour:
- Clock and reset: one clock (clk); reset_n is asynchronous, active-low.
- Reset values:
  - State = INIT.
  - div64 = 0, div15 = 0.
  - poly_enable = 0, poly_init = 1, select_9_17 = 0.
  - tick_64k = 0, tick_15k = 0.
  - rand_data = 8'h00, rand_valid = 0.
- FSM states: INIT, SYNC, RUN. Transitions are evaluated on clk edges with ce=1 only.
  - INIT -> SYNC when skctl_init=0.
  - SYNC -> RUN unconditionally on the next ce.
  - Any state -> INIT when skctl_init=1; this has priority over all other transitions.
- INIT state:
  - poly_init=1, poly_enable=1 (the poly keeps shifting, flushing zeros).
  - div64 and div15 held at 0; ticks held at 0.
- SYNC state:
  - poly_init=0, poly_enable=1.
  - Counters still held at 0; no ticks.
- RUN state:
  - poly_init=0, poly_enable=1.
  - div64 counts 0..DIV_64K-1 and wraps to 0. tick_64k=1 for the ce cycle in which div64==DIV_64K-1.
  - div15 counts 0..DIV_15K-1 and wraps to 0. tick_15k=1 for the ce cycle in which div15==DIV_15K-1.
  - Both counters are 7 bits wide and independent.
- Register and tick timing:
  - All outputs are registered.
  - Tick outputs hold their value between ce cycles. They are qualified downstream by ce.
  - First tick_64k occurs on the DIV_64K-th ce cycle after entering RUN; first tick_15k on the DIV_15K-th.
- select_9_17:
  - Registered copy of audctl_poly9, sampled on every ce in every state.
  - Latency: 1 ce cycle.
- RANDOM read:
  - On rand_rd=1 (independent of ce), rand_data is loaded on the same clk edge: INIT_RAND if state==INIT, else rand_in.
  - rand_valid=1 for exactly the following clk cycle.
  - Back-to-back rand_rd pulses each produce a load and a rand_valid pulse.
  - A rand_rd coincident with the transition into INIT uses the pre-edge state.
- Reset mid-operation: reset_n low at any time immediately forces all reset values, including during a rand_valid pulse.
- ce=0:
  - FSM, counters and select_9_17 are frozen.
  - The RANDOM read path still operates.

Test Plan:
- Reset release with skctl_init=1 -> poly_init=1, poly_enable=1 on ce, no ticks for 500 ce cycles, rand_rd returns 8'hFF with rand_valid one clk later.
- Drop skctl_init -> one SYNC ce with poly_init=0 and no tick, then tick_64k at ce #28 and #56 of RUN, tick_15k at ce #114 and #228.
- ce asserted only 1 in 3 clks in RUN -> tick spacing exactly 28×3 clks and 114×3 clks; counters never advance on ce=0.
- Toggle audctl_poly9 0->1 -> select_9_17 rises on the next ce edge, not before; ce held low delays it.
- rand_in=8'hA5 in RUN, two rand_rd pulses 1 clk apart -> rand_data=8'hA5, rand_valid high for 2 consecutive clks.
- Reassert skctl_init at div64=20, then release -> counters restart from 0 and the next tick_64k is 28 ce cycles after entering RUN; async reset_n pulse mid-RUN -> all outputs at reset values immediately.

Source files
------------

// File: rtl/pokey_poly_sched.sv
// rtl/pokey_poly_sched.sv - POKEY poly counter sequencer, 64k/15k tick prescalers and RANDOM read latch
module pokey_poly_sched #(
  parameter int unsigned DIV_64K   = 28,
  parameter int unsigned DIV_15K   = 114,
  parameter logic [7:0]  INIT_RAND = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       skctl_init,
  input  logic       audctl_poly9,
  input  logic [7:0] rand_in,
  input  logic       rand_rd,
  output logic       poly_enable,
  output logic       poly_init,
  output logic       select_9_17,
  output logic       tick_64k,
  output logic       tick_15k,
  output logic [7:0] rand_data,
  output logic       rand_valid
);

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [6:0] DIV64_LAST = 7'(DIV_64K - 1);
  localparam logic [6:0] DIV15_LAST = 7'(DIV_15K - 1);

  state_e     state_q, state_d;
  logic [6:0] div64_q, div64_d;
  logic [6:0] div15_q, div15_d;
  logic       poly_enable_q, poly_enable_d;
  logic       poly_init_q, poly_init_d;
  logic       select_9_17_q, select_9_17_d;
  logic       tick_64k_q, tick_64k_d;
  logic       tick_15k_q, tick_15k_d;
  logic [7:0] rand_data_q, rand_data_d;
  logic       rand_valid_q, rand_valid_d;

  always_comb begin
    state_d       = state_q;
    div64_d       = div64_q;
    div15_d       = div15_q;
    poly_enable_d = poly_enable_q;
    poly_init_d   = poly_init_q;
    select_9_17_d = select_9_17_q;
    tick_64k_d    = tick_64k_q;
    tick_15k_d    = tick_15k_q;
    rand_valid_d  = rand_rd;
    rand_data_d   = rand_data_q;

    // RANDOM reads run every clk and see the state before this edge
    if (rand_rd) begin
      rand_data_d = (state_q == ST_INIT) ? INIT_RAND : rand_in;
    end

    if (ce) begin
      select_9_17_d = audctl_poly9;
      poly_enable_d = 1'b1;
      if (skctl_init) begin
        state_d = ST_INIT;
      end else begin
        case (state_q)
          ST_INIT: state_d = ST_SYNC;
          ST_SYNC: state_d = ST_RUN;
          default: state_d = ST_RUN;
        endcase
      end
      poly_init_d = (state_d == ST_INIT);

      // Prescalers only run while staying in RUN; any other path restarts them
      if (state_q == ST_RUN && state_d == ST_RUN) begin
        div64_d    = (div64_q == DIV64_LAST) ? 7'd0 : div64_q + 7'd1;
        div15_d    = (div15_q == DIV15_LAST) ? 7'd0 : div15_q + 7'd1;
        tick_64k_d = (div64_q == DIV64_LAST);
        tick_15k_d = (div15_q == DIV15_LAST);
      end else begin
        div64_d    = 7'd0;
        div15_d    = 7'd0;
        tick_64k_d = 1'b0;
        tick_15k_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_INIT;
      div64_q       <= 7'd0;
      div15_q       <= 7'd0;
      poly_enable_q <= 1'b0;
      poly_init_q   <= 1'b1;
      select_9_17_q <= 1'b0;
      tick_64k_q    <= 1'b0;
      tick_15k_q    <= 1'b0;
      rand_data_q   <= 8'h00;
      rand_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      div64_q       <= div64_d;
      div15_q       <= div15_d;
      poly_enable_q <= poly_enable_d;
      poly_init_q   <= poly_init_d;
      select_9_17_q <= select_9_17_d;
      tick_64k_q    <= tick_64k_d;
      tick_15k_q    <= tick_15k_d;
      rand_data_q   <= rand_data_d;
      rand_valid_q  <= rand_valid_d;
    end
  end

  assign poly_enable = poly_enable_q;
  assign poly_init   = poly_init_q;
  assign select_9_17 = select_9_17_q;
  assign tick_64k    = tick_64k_q;
  assign tick_15k    = tick_15k_q;
  assign rand_data   = rand_data_q;
  assign rand_valid  = rand_valid_q;

endmodule

// File: tb/tb_pokey_poly_sched.sv
// tb/tb_pokey_poly_sched.sv - randomized bench for pokey_poly_sched against a ce-count reference model
module tb_pokey_poly_sched;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ce = 1'b0;
  logic       skctl_init = 1'b1;
  logic       audctl_poly9 = 1'b0;
  logic [7:0] rand_in = 8'h00;
  logic       rand_rd = 1'b0;
  logic       poly_enable, poly_init, select_9_17, tick_64k, tick_15k, rand_valid;
  logic [7:0] rand_data;

  int total = 0;
  int bad = 0;

  pokey_poly_sched dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .skctl_init(skctl_init),
    .audctl_poly9(audctl_poly9), .rand_in(rand_in), .rand_rd(rand_rd),
    .poly_enable(poly_enable), .poly_init(poly_init), .select_9_17(select_9_17),
    .tick_64k(tick_64k), .tick_15k(tick_15k), .rand_data(rand_data), .rand_valid(rand_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_n counts ce edges since the last edge that saw skctl_init high (or reset).
  // 0 = INIT, 1 = SYNC, n>=2 = RUN with (n-2) ce edges elapsed since entering RUN.
  int       m_n = 0;
  bit       m_any_ce = 0;
  bit       m_sel = 0;
  bit [7:0] m_rdata = 8'h00;
  bit       m_rvalid = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n = 0; m_any_ce = 0; m_sel = 0; m_rdata = 8'h00; m_rvalid = 0;
    end else begin
      m_rvalid = rand_rd;
      if (rand_rd) m_rdata = (m_n == 0) ? 8'hFF : rand_in;
      if (ce) begin
        m_any_ce = 1;
        m_sel = audctl_poly9;
        m_n = skctl_init ? 0 : m_n + 1;
      end
    end
  end

  function automatic bit exp_tick(input int n, input int div);
    return (n > 2) && (((n - 2) % div) == 0);
  endfunction

  int clk_idx = 0;
  bit prev64 = 0, prev15 = 0;
  int q64[$];
  int q15[$];

  always @(negedge clk) begin
    clk_idx++;
    check("poly_enable", poly_enable, m_any_ce);
    check("poly_init", poly_init, m_n == 0);
    check("select_9_17", select_9_17, m_sel);
    check("tick_64k", tick_64k, exp_tick(m_n, 28));
    check("tick_15k", tick_15k, exp_tick(m_n, 114));
    check("rand_data", rand_data, m_rdata);
    check("rand_valid", rand_valid, m_rvalid);
    if (tick_64k && !prev64) q64.push_back(clk_idx);
    if (tick_15k && !prev15) q15.push_back(clk_idx);
    prev64 = tick_64k;
    prev15 = tick_15k;
  end

  task automatic tick_clk();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int cnt;
    int k64[$];
    int k15[$];
    int first;

    @(posedge clk); #2;
    repeat (3) tick_clk();
    check("rst_poly_init", poly_init, 1);
    check("rst_poly_enable", poly_enable, 0);
    check("rst_rand_data", rand_data, 8'h00);
    check("rst_ticks", {tick_64k, tick_15k}, 0);

    // INIT hold: no ticks, RANDOM reads return the init value
    reset_n = 1'b1;
    skctl_init = 1'b1;
    ce = 1'b1;
    cnt = 0;
    repeat (500) begin
      tick_clk();
      if (tick_64k || tick_15k) cnt++;
    end
    check("init_no_ticks", cnt, 0);
    check("init_poly_init", poly_init, 1);
    check("init_poly_enable", poly_enable, 1);
    rand_in = 8'h3C;
    rand_rd = 1'b1;
    tick_clk();
    rand_rd = 1'b0;
    check("init_rand_valid", rand_valid, 1);
    check("init_rand_data", rand_data, 8'hFF);
    tick_clk();
    check("init_rand_valid_low", rand_valid, 0);

    // SYNC then RUN tick positions
    skctl_init = 1'b0;
    tick_clk();
    check("sync_poly_init", poly_init, 0);
    check("sync_no_tick", tick_64k, 0);
    tick_clk();
    for (int k = 1; k <= 230; k++) begin
      tick_clk();
      if (tick_64k) k64.push_back(k);
      if (tick_15k) k15.push_back(k);
    end
    check("run_64k_count", k64.size(), 8);
    check("run_64k_first", k64[0], 28);
    check("run_64k_second", k64[1], 56);
    check("run_15k_count", k15.size(), 2);
    check("run_15k_first", k15[0], 114);
    check("run_15k_second", k15[1], 228);

    // ce one clk in three: tick spacing in clks
    q64.delete();
    q15.delete();
    for (int i = 0; i < 1200; i++) begin
      ce = (i % 3 == 0);
      tick_clk();
    end
    check("slow_64k_count_ok", q64.size() >= 3, 1);
    check("slow_15k_count_ok", q15.size() >= 2, 1);
    if (q64.size() >= 3) begin
      check("slow_64k_gap0", q64[1] - q64[0], 84);
      check("slow_64k_gap1", q64[2] - q64[1], 84);
    end
    if (q15.size() >= 2) check("slow_15k_gap", q15[1] - q15[0], 342);

    // select_9_17 waits for ce
    ce = 1'b0;
    audctl_poly9 = 1'b1;
    repeat (3) tick_clk();
    check("sel_held_no_ce", select_9_17, 0);
    ce = 1'b1;
    tick_clk();
    check("sel_after_ce", select_9_17, 1);
    audctl_poly9 = 1'b0;

    // back-to-back RANDOM reads in RUN
    rand_in = 8'hA5;
    rand_rd = 1'b1;
    tick_clk();
    check("rd_valid_1", rand_valid, 1);
    check("rd_data_1", rand_data, 8'hA5);
    tick_clk();
    rand_rd = 1'b0;
    check("rd_valid_2", rand_valid, 1);
    tick_clk();
    check("rd_valid_end", rand_valid, 0);
    check("rd_data_end", rand_data, 8'hA5);

    // re-init mid-count restarts the prescalers
    skctl_init = 1'b1; tick_clk();
    skctl_init = 1'b0; tick_clk(); tick_clk();
    repeat (20) tick_clk();
    skctl_init = 1'b1;
    tick_clk();
    check("reinit_poly_init", poly_init, 1);
    check("reinit_tick", tick_64k, 0);
    skctl_init = 1'b0;
    tick_clk(); tick_clk();
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      tick_clk();
      if (tick_64k && first == 0) first = k;
    end
    check("reinit_first_64k", first, 28);

    // async reset during a rand_valid pulse
    rand_rd = 1'b1;
    tick_clk();
    rand_rd = 1'b0;
    check("pre_rst_valid", rand_valid, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_rand_valid", rand_valid, 0);
    check("async_rand_data", rand_data, 8'h00);
    check("async_poly_init", poly_init, 1);
    check("async_poly_enable", poly_enable, 0);
    check("async_select", select_9_17, 0);
    tick_clk();
    reset_n = 1'b1;

    // randomized traffic checked by the model
    for (int i = 0; i < 5000; i++) begin
      ce = ($urandom_range(0, 3) != 0);
      rand_in = 8'($urandom);
      rand_rd = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) audctl_poly9 = 1'($urandom);
      if (skctl_init) skctl_init = ($urandom_range(0, 5) != 0);
      else skctl_init = ($urandom_range(0, 799) == 0);
      tick_clk();
    end
    rand_rd = 1'b0;
    tick_clk();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
